// File: rtl/na_conf_arbiter.sv
// Round-robin arbiter that shares one configuration-register slave among
// NUM_REQ bus requesters, with a slave response timeout and requester abort.
module na_conf_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      m_cyc_i,
  input  logic [NUM_REQ-1:0]      m_stb_i,
  input  logic [NUM_REQ-1:0]      m_we_i,
  input  logic [16*NUM_REQ-1:0]   m_adr_i,
  input  logic [32*NUM_REQ-1:0]   m_dat_i,
  output logic [31:0]             m_dat_o,
  output logic [NUM_REQ-1:0]      m_ack_o,
  output logic [NUM_REQ-1:0]      m_err_o,
  output logic [NUM_REQ-1:0]      m_rty_o,
  output logic                    s_stb_o,
  output logic                    s_we_o,
  output logic [15:0]             s_adr_o,
  output logic [31:0]             s_dat_o,
  input  logic [31:0]             s_dat_i,
  input  logic                    s_ack_i,
  input  logic                    s_err_i,
  input  logic                    s_rty_i
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = GW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;
  typedef enum logic [1:0] {RSP_NONE = 2'd0, RSP_ACK = 2'd1, RSP_ERR = 2'd2, RSP_RTY = 2'd3} resp_t;

  state_t             state_r, state_s;
  resp_t              resp_r, resp_s;
  logic [GW-1:0]      grant_r, grant_s, last_r, last_s, pick_s;
  logic [7:0]         cnt_r, cnt_s;
  logic [31:0]        data_r, data_s;
  logic [NUM_REQ-1:0] pend_s, gmask_s;
  logic [CW-1:0]      cand_s;
  logic               found_s, hit_s, cyc_g_s;
  logic               sel_we_s;
  logic [15:0]        sel_adr_s;
  logic [31:0]        sel_dat_s;

  assign pend_s = m_cyc_i & m_stb_i;

  // Select the granted requester's signals as a one-hot AND-OR mux.
  always_comb begin
    gmask_s   = '0;
    sel_we_s  = 1'b0;
    sel_adr_s = 16'h0000;
    sel_dat_s = 32'h0000_0000;
    for (int k = 0; k < NUM_REQ; k++) begin
      gmask_s[k] = (grant_r == GW'(k));
      sel_we_s   = sel_we_s | (gmask_s[k] & m_we_i[k]);
      sel_adr_s  = sel_adr_s | ({16{gmask_s[k]}} & m_adr_i[16*k +: 16]);
      sel_dat_s  = sel_dat_s | ({32{gmask_s[k]}} & m_dat_i[32*k +: 32]);
    end
    cyc_g_s = |(m_cyc_i & gmask_s);
  end

  // Round-robin search: first pending index after last, wrapping around.
  always_comb begin
    found_s = 1'b0;
    hit_s   = 1'b0;
    pick_s  = '0;
    cand_s  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_s = {1'b0, last_r} + CW'(i);
      cand_s = (cand_s >= CW'(NUM_REQ)) ? (cand_s - CW'(NUM_REQ)) : cand_s;
      for (int k = 0; k < NUM_REQ; k++) begin
        hit_s   = ~found_s & pend_s[k] & (cand_s == CW'(k));
        pick_s  = hit_s ? GW'(k) : pick_s;
        found_s = found_s | hit_s;
      end
    end
  end

  // Next-state logic; a dropped m_cyc_i outranks any same-cycle slave response.
  always_comb begin
    state_s = state_r;
    grant_s = grant_r;
    last_s  = last_r;
    cnt_s   = cnt_r;
    data_s  = data_r;
    resp_s  = resp_r;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          grant_s = pick_s;
          cnt_s   = 8'd0;
          state_s = BUSY;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        cnt_s = cnt_r + 8'd1;
        if (!cyc_g_s) begin
          last_s  = grant_r;
          state_s = IDLE;
        end else if (s_err_i) begin
          resp_s  = RSP_ERR;
          data_s  = s_dat_i;
          state_s = RESP;
        end else if (s_rty_i) begin
          resp_s  = RSP_RTY;
          data_s  = s_dat_i;
          state_s = RESP;
        end else if (s_ack_i) begin
          resp_s  = RSP_ACK;
          data_s  = s_dat_i;
          state_s = RESP;
        end else if (cnt_r == 8'(TIMEOUT - 1)) begin
          resp_s  = RSP_ERR;
          data_s  = 32'h0000_0000;
          state_s = RESP;
        end else begin
          state_s = BUSY;
        end
      end
      RESP: begin
        last_s  = grant_r;
        resp_s  = RSP_NONE;
        data_s  = 32'h0000_0000;
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
      grant_r <= '0;
      last_r  <= GW'(NUM_REQ - 1);
      cnt_r   <= 8'd0;
      data_r  <= 32'h0000_0000;
      resp_r  <= RSP_NONE;
    end else begin
      state_r <= state_s;
      grant_r <= grant_s;
      last_r  <= last_s;
      cnt_r   <= cnt_s;
      data_r  <= data_s;
      resp_r  <= resp_s;
    end
  end

  // Output decode from the registered state.
  always_comb begin
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = 16'h0000;
    s_dat_o = 32'h0000_0000;
    m_dat_o = 32'h0000_0000;
    m_ack_o = '0;
    m_err_o = '0;
    m_rty_o = '0;
    case (state_r)
      BUSY: begin
        s_stb_o = 1'b1;
        s_we_o  = sel_we_s;
        s_adr_o = sel_adr_s;
        s_dat_o = sel_dat_s;
      end
      RESP: begin
        m_dat_o = data_r;
        m_ack_o = (resp_r == RSP_ACK) ? gmask_s : '0;
        m_err_o = (resp_r == RSP_ERR) ? gmask_s : '0;
        m_rty_o = (resp_r == RSP_RTY) ? gmask_s : '0;
      end
      default: begin
        s_stb_o = 1'b0;
      end
    endcase
  end
endmodule

// File: tb/tb_na_conf_arbiter.sv
// Directed self-checking bench for na_conf_arbiter (NUM_REQ=2, TIMEOUT=4).
module tb_na_conf_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  m_cyc_i, m_stb_i, m_we_i;
  logic [31:0] m_adr_i;
  logic [63:0] m_dat_i;
  logic [31:0] m_dat_o;
  logic [1:0]  m_ack_o, m_err_o, m_rty_o;
  logic        s_stb_o, s_we_o;
  logic [15:0] s_adr_o;
  logic [31:0] s_dat_o;
  logic [31:0] s_dat_i;
  logic        s_ack_i, s_err_i, s_rty_i;

  int n_cmp  = 0;
  int n_fail = 0;

  na_conf_arbiter #(.NUM_REQ(2), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drop_all;
    m_cyc_i = 2'b00; m_stb_i = 2'b00;
    s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
  endtask

  task automatic test_reset;
    logic [184:0] outs;
    rst = 1'b0; m_we_i = 2'b00; m_adr_i = 32'h0; m_dat_i = 64'h0; s_dat_i = 32'h0;
    drop_all();
    tick(); tick();
    outs = {m_dat_o, m_ack_o, m_err_o, m_rty_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, 86'd0};
    n_cmp++;
    if (outs !== 185'd0) begin n_fail++; $display("FAIL reset_outs: got %h expected 0", outs); end
    m_cyc_i = 2'b01; m_stb_i = 2'b01; s_ack_i = 1'b1;
    tick();
    outs = {m_dat_o, m_ack_o, m_err_o, m_rty_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, 86'd0};
    n_cmp++;
    if (outs !== 185'd0) begin n_fail++; $display("FAIL reset_hold: got %h expected 0", outs); end
    drop_all();
  endtask

  task automatic test_single_read;
    rst = 1'b1;
    m_cyc_i = 2'b01; m_stb_i = 2'b01; m_we_i = 2'b00;
    m_adr_i = {16'h0000, 16'h0004}; s_ack_i = 1'b1; s_dat_i = 32'h0000_0010;
    #1;
    n_cmp++;
    if (s_stb_o !== 1'b0) begin n_fail++; $display("FAIL single_c0_stb: got %b expected 0", s_stb_o); end
    tick();
    n_cmp++;
    if (s_stb_o !== 1'b1) begin n_fail++; $display("FAIL single_c1_stb: got %b expected 1", s_stb_o); end
    n_cmp++;
    if (s_adr_o !== 16'h0004) begin n_fail++; $display("FAIL single_c1_adr: got %h expected 0004", s_adr_o); end
    n_cmp++;
    if (m_ack_o !== 2'b00) begin n_fail++; $display("FAIL single_c1_ack: got %b expected 00", m_ack_o); end
    tick();
    n_cmp++;
    if (m_ack_o !== 2'b01) begin n_fail++; $display("FAIL single_c2_ack: got %b expected 01", m_ack_o); end
    n_cmp++;
    if (m_dat_o !== 32'h0000_0010) begin n_fail++; $display("FAIL single_c2_dat: got %h expected 00000010", m_dat_o); end
    n_cmp++;
    if (s_stb_o !== 1'b0) begin n_fail++; $display("FAIL single_c2_stb: got %b expected 0", s_stb_o); end
    drop_all();
    tick();
    n_cmp++;
    if ({m_ack_o, m_dat_o} !== 34'd0) begin n_fail++; $display("FAIL single_c3_idle: got %h expected 0", {m_ack_o, m_dat_o}); end
  endtask

  task automatic test_back_to_back;
    logic        e_stb, e_we, g;
    logic [15:0] e_adr;
    logic [1:0]  e_ack;
    logic [31:0] e_dat;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    m_cyc_i = 2'b11; m_stb_i = 2'b11; m_we_i = 2'b10;
    m_adr_i = {16'h0200, 16'h0100}; m_dat_i = {32'hCAFE_0001, 32'h1234_5678};
    s_ack_i = 1'b1; s_dat_i = 32'h0000_BEEF;
    #1;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) tick();
      g     = ((c / 3) % 2) == 1;
      e_stb = (c % 3) == 1;
      e_adr = e_stb ? (g ? 16'h0200 : 16'h0100) : 16'h0000;
      e_we  = e_stb && g;
      e_ack = ((c % 3) == 2) ? (g ? 2'b10 : 2'b01) : 2'b00;
      e_dat = ((c % 3) == 2) ? 32'h0000_BEEF : 32'h0000_0000;
      n_cmp++;
      if (s_stb_o !== e_stb) begin n_fail++; $display("FAIL b2b_stb c%0d: got %b expected %b", c, s_stb_o, e_stb); end
      n_cmp++;
      if (s_adr_o !== e_adr) begin n_fail++; $display("FAIL b2b_adr c%0d: got %h expected %h", c, s_adr_o, e_adr); end
      n_cmp++;
      if (s_we_o !== e_we) begin n_fail++; $display("FAIL b2b_we c%0d: got %b expected %b", c, s_we_o, e_we); end
      n_cmp++;
      if (m_ack_o !== e_ack) begin n_fail++; $display("FAIL b2b_ack c%0d: got %b expected %b", c, m_ack_o, e_ack); end
      n_cmp++;
      if (m_dat_o !== e_dat) begin n_fail++; $display("FAIL b2b_dat c%0d: got %h expected %h", c, m_dat_o, e_dat); end
    end
    n_cmp++;
    if (s_dat_o !== 32'h0) begin n_fail++; $display("FAIL b2b_sdat_resp: got %h expected 0", s_dat_o); end
    drop_all();
    tick();
  endtask

  task automatic test_timeout;
    m_cyc_i = 2'b01; m_stb_i = 2'b01; m_we_i = 2'b00;
    m_adr_i = {16'h0000, 16'h0040}; s_dat_i = 32'hDEAD_BEEF;
    s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      n_cmp++;
      if (s_stb_o !== (c <= 4)) begin n_fail++; $display("FAIL timeout_stb c%0d: got %b expected %b", c, s_stb_o, (c <= 4)); end
      n_cmp++;
      if (m_err_o !== ((c == 5) ? 2'b01 : 2'b00)) begin n_fail++; $display("FAIL timeout_err c%0d: got %b", c, m_err_o); end
      if (c == 5) begin
        n_cmp++;
        if (m_dat_o !== 32'h0) begin n_fail++; $display("FAIL timeout_dat: got %h expected 0", m_dat_o); end
        drop_all();
      end
    end
  endtask

  task automatic test_abort;
    m_cyc_i = 2'b10; m_stb_i = 2'b10; m_adr_i = {16'h0300, 16'h0100};
    tick();
    n_cmp++;
    if ({s_stb_o, s_adr_o} !== {1'b1, 16'h0300}) begin n_fail++; $display("FAIL abort_busy: got %h expected 10300", {s_stb_o, s_adr_o}); end
    m_cyc_i = 2'b00; s_ack_i = 1'b1; s_dat_i = 32'h0000_0055;
    tick();
    n_cmp++;
    if (m_ack_o !== 2'b00) begin n_fail++; $display("FAIL abort_noack: got %b expected 00", m_ack_o); end
    n_cmp++;
    if (s_stb_o !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got %b expected 0", s_stb_o); end
    m_cyc_i = 2'b11; m_stb_i = 2'b11;
    tick();
    n_cmp++;
    if (s_adr_o !== 16'h0100) begin n_fail++; $display("FAIL abort_regrant: got %h expected 0100", s_adr_o); end
    tick();
    n_cmp++;
    if (m_ack_o !== 2'b01) begin n_fail++; $display("FAIL abort_ack0: got %b expected 01", m_ack_o); end
    drop_all();
    tick();
  endtask

  task automatic test_reset_busy;
    m_cyc_i = 2'b10; m_stb_i = 2'b10;
    tick();
    n_cmp++;
    if (s_stb_o !== 1'b1) begin n_fail++; $display("FAIL rstbusy_stb: got %b expected 1", s_stb_o); end
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({m_dat_o, m_ack_o, m_err_o, m_rty_o, s_stb_o, s_we_o, s_adr_o, s_dat_o} !== 99'd0) begin
      n_fail++; $display("FAIL rstbusy_zero: got %h expected 0", {m_dat_o, m_ack_o, m_err_o, m_rty_o, s_stb_o, s_we_o, s_adr_o, s_dat_o});
    end
    rst = 1'b1; m_cyc_i = 2'b11; m_stb_i = 2'b11; s_ack_i = 1'b1;
    tick();
    n_cmp++;
    if (s_adr_o !== 16'h0100) begin n_fail++; $display("FAIL rstbusy_grant0: got %h expected 0100", s_adr_o); end
    tick();
    n_cmp++;
    if (m_ack_o !== 2'b01) begin n_fail++; $display("FAIL rstbusy_ack: got %b expected 01", m_ack_o); end
    drop_all();
    tick();
  endtask

  task automatic test_err_ack;
    m_cyc_i = 2'b01; m_stb_i = 2'b01; s_err_i = 1'b1; s_ack_i = 1'b1; s_dat_i = 32'hA5A5_A5A5;
    tick(); tick();
    n_cmp++;
    if ({m_err_o, m_ack_o} !== 4'b0100) begin n_fail++; $display("FAIL errack_resp: got %b expected 0100", {m_err_o, m_ack_o}); end
    n_cmp++;
    if (m_dat_o !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL errack_dat: got %h expected a5a5a5a5", m_dat_o); end
    drop_all();
    tick();
    n_cmp++;
    if (m_err_o !== 2'b00) begin n_fail++; $display("FAIL errack_onecycle: got %b expected 00", m_err_o); end
    m_cyc_i = 2'b10; m_stb_i = 2'b10; s_rty_i = 1'b1; s_ack_i = 1'b1;
    tick(); tick();
    n_cmp++;
    if ({m_rty_o, m_ack_o} !== 4'b1000) begin n_fail++; $display("FAIL rtyack_resp: got %b expected 1000", {m_rty_o, m_ack_o}); end
    drop_all();
    tick();
    n_cmp++;
    if (m_rty_o !== 2'b00) begin n_fail++; $display("FAIL rtyack_onecycle: got %b expected 00", m_rty_o); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_timeout();
    test_abort();
    test_reset_busy();
    test_err_ack();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
